// File: rtl/instruction_decode.sv
// ============================================================================
// Module   : instruction_decode
// Purpose  : MIPS-subset decode stage with 32x32 register file and ID/EX register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_decode #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 7,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      flush,
    input  logic [PC_WIDTH-1:0]       pc_in,
    input  logic [DATA_WIDTH-1:0]     instruction,
    input  logic                      wb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] wb_write_addr,
    input  logic [DATA_WIDTH-1:0]     wb_write_data,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    output logic [DATA_WIDTH-1:0]     sign_ext_imm,
    output logic [REG_ADDR_WIDTH-1:0] rs_addr,
    output logic [REG_ADDR_WIDTH-1:0] rt_addr,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [5:0]                funct,
    output logic [PC_WIDTH-1:0]       jump_target,
    output logic                      reg_dst,
    output logic                      alu_src,
    output logic                      mem_to_reg,
    output logic                      reg_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      branch,
    output logic                      jump,
    output logic [1:0]                alu_op,
    output logic                      illegal
);

    localparam int         c_NUM_REGS  = 1 << REG_ADDR_WIDTH;
    localparam logic [5:0] c_OP_RTYPE  = 6'h00;
    localparam logic [5:0] c_OP_LW     = 6'h23;
    localparam logic [5:0] c_OP_SW     = 6'h2B;
    localparam logic [5:0] c_OP_BEQ    = 6'h04;
    localparam logic [5:0] c_OP_ADDI   = 6'h08;
    localparam logic [5:0] c_OP_J      = 6'h02;
    localparam logic [1:0] c_ALU_ADD   = 2'b00;
    localparam logic [1:0] c_ALU_SUB   = 2'b01;
    localparam logic [1:0] c_ALU_RTYPE = 2'b10;

    logic [DATA_WIDTH-1:0]     r_regs [c_NUM_REGS];

    logic [5:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_rs;
    logic [REG_ADDR_WIDTH-1:0] w_rt;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [DATA_WIDTH-1:0]     w_imm;
    logic                      w_wb_we;
    logic [DATA_WIDTH-1:0]     w_rs_data;
    logic [DATA_WIDTH-1:0]     w_rt_data;
    logic [7:0]                w_ctrl;
    logic [1:0]                w_alu_op;
    logic                      w_illegal;

    logic [PC_WIDTH-1:0]       r_pc;
    logic [DATA_WIDTH-1:0]     r_rd1;
    logic [DATA_WIDTH-1:0]     r_rd2;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs;
    logic [REG_ADDR_WIDTH-1:0] r_rt;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [5:0]                r_funct;
    logic [PC_WIDTH-1:0]       r_jt;
    logic [7:0]                r_ctrl;
    logic [1:0]                r_alu_op;
    logic                      r_illegal;

    assign w_opcode = instruction[31:26];
    assign w_rs     = instruction[25:21];
    assign w_rt     = instruction[20:16];
    assign w_rd     = instruction[15:11];
    assign w_imm    = {{(DATA_WIDTH-16){instruction[15]}}, instruction[15:0]};
    assign w_wb_we  = wb_reg_write && (wb_write_addr != '0);

    // Register 0 is never written, so its entry stays at the reset value of 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[wb_write_addr] <= wb_write_data;
        end
    end

    // Same-edge write-back is forwarded so decode never sees a stale operand.
    always_comb begin
        w_rs_data = r_regs[w_rs];
        w_rt_data = r_regs[w_rt];
        if (w_wb_we && (wb_write_addr == w_rs)) w_rs_data = wb_write_data;
        if (w_wb_we && (wb_write_addr == w_rt)) w_rt_data = wb_write_data;
        if (w_rs == '0) w_rs_data = '0;
        if (w_rt == '0) w_rt_data = '0;
    end

    // w_ctrl = {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
    always_comb begin
        w_ctrl    = 8'b0;
        w_alu_op  = c_ALU_ADD;
        w_illegal = 1'b0;
        case (w_opcode)
            c_OP_RTYPE: begin
                w_ctrl   = 8'b1001_0000;
                w_alu_op = c_ALU_RTYPE;
            end
            c_OP_LW:   w_ctrl = 8'b0111_1000;
            c_OP_SW:   w_ctrl = 8'b0100_0100;
            c_OP_BEQ: begin
                w_ctrl   = 8'b0000_0010;
                w_alu_op = c_ALU_SUB;
            end
            c_OP_ADDI: w_ctrl = 8'b0101_0000;
            c_OP_J:    w_ctrl = 8'b0000_0001;
            default:   w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset || flush) begin
            if (!reset || flush) begin
                r_pc      <= '0;
                r_rd1     <= '0;
                r_rd2     <= '0;
                r_imm     <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_funct   <= '0;
                r_jt      <= '0;
                r_ctrl    <= '0;
                r_alu_op  <= '0;
                r_illegal <= 1'b0;
            end
        end else if (enable) begin
            r_pc      <= pc_in;
            r_rd1     <= w_rs_data;
            r_rd2     <= w_rt_data;
            r_imm     <= w_imm;
            r_rs      <= w_rs;
            r_rt      <= w_rt;
            r_rd      <= w_rd;
            r_funct   <= instruction[5:0];
            r_jt      <= instruction[PC_WIDTH-1:0];
            r_ctrl    <= w_ctrl;
            r_alu_op  <= w_alu_op;
            r_illegal <= w_illegal;
        end
    end

    assign pc_out       = r_pc;
    assign read_data_1  = r_rd1;
    assign read_data_2  = r_rd2;
    assign sign_ext_imm = r_imm;
    assign rs_addr      = r_rs;
    assign rt_addr      = r_rt;
    assign rd_addr      = r_rd;
    assign funct        = r_funct;
    assign jump_target  = r_jt;
    assign {reg_dst, alu_src, mem_to_reg, reg_write,
            mem_read, mem_write, branch, jump} = r_ctrl;
    assign alu_op       = r_alu_op;
    assign illegal      = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// ============================================================================
// Module   : tb_instruction_decode
// Purpose  : Scoreboard bench for instruction_decode with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_decode;

    typedef struct {
        logic [6:0]  pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [6:0]  jt;
        logic [7:0]  ctrl;
        logic [1:0]  alu_op;
        logic        illegal;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [6:0]  pc_in;
    logic [31:0] instruction;
    logic        wb_reg_write;
    logic [4:0]  wb_write_addr;
    logic [31:0] wb_write_data;
    logic [6:0]  pc_out;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] sign_ext_imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [5:0]  funct;
    logic [6:0]  jump_target;
    logic        reg_dst, alu_src, mem_to_reg, reg_write;
    logic        mem_read, mem_write, branch, jump;
    logic [1:0]  alu_op;
    logic        illegal;

    int          total = 0;
    int          bad   = 0;
    exp_t        scb[$];
    exp_t        prev;
    exp_t        zero_e;
    logic [31:0] m_regs [32];

    instruction_decode #(
        .DATA_WIDTH(32),
        .PC_WIDTH(7),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .pc_in(pc_in), .instruction(instruction),
        .wb_reg_write(wb_reg_write), .wb_write_addr(wb_write_addr),
        .wb_write_data(wb_write_data),
        .pc_out(pc_out), .read_data_1(read_data_1), .read_data_2(read_data_2),
        .sign_ext_imm(sign_ext_imm), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rd_addr(rd_addr), .funct(funct), .jump_target(jump_target),
        .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .jump(jump), .alu_op(alu_op), .illegal(illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare(input exp_t e);
        chk("pc_out",      32'(pc_out),       32'(e.pc));
        chk("read_data_1", read_data_1,       e.rd1);
        chk("read_data_2", read_data_2,       e.rd2);
        chk("sign_ext",    sign_ext_imm,      e.imm);
        chk("rs_addr",     32'(rs_addr),      32'(e.rs));
        chk("rt_addr",     32'(rt_addr),      32'(e.rt));
        chk("rd_addr",     32'(rd_addr),      32'(e.rd));
        chk("funct",       32'(funct),        32'(e.funct));
        chk("jump_target", 32'(jump_target),  32'(e.jt));
        chk("ctrl",        32'({reg_dst, alu_src, mem_to_reg, reg_write,
                                mem_read, mem_write, branch, jump}), 32'(e.ctrl));
        chk("alu_op",      32'(alu_op),       32'(e.alu_op));
        chk("illegal",     32'(illegal),      32'(e.illegal));
    endtask

    // Control vector order: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump
    function automatic exp_t decode_model(input logic [31:0] ins, input logic [6:0] pc,
                                          input logic wbw, input logic [4:0] wba,
                                          input logic [31:0] wbd);
        exp_t e;
        logic [4:0] rs, rt;
        rs       = ins[25:21];
        rt       = ins[20:16];
        e.pc     = pc;
        e.rs     = rs;
        e.rt     = rt;
        e.rd     = ins[15:11];
        e.funct  = ins[5:0];
        e.jt     = ins[6:0];
        e.imm    = ins[15] ? {16'hFFFF, ins[15:0]} : {16'h0000, ins[15:0]};
        e.rd1    = (rs == 0) ? 32'h0 : ((wbw && wba != 0 && wba == rs) ? wbd : m_regs[rs]);
        e.rd2    = (rt == 0) ? 32'h0 : ((wbw && wba != 0 && wba == rt) ? wbd : m_regs[rt]);
        e.ctrl    = 8'h00;
        e.alu_op  = 2'b00;
        e.illegal = 1'b0;
        case (ins[31:26])
            6'h00: begin e.ctrl = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0}; e.alu_op = 2'b10; end
            6'h23: e.ctrl = {1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0};
            6'h2B: e.ctrl = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};
            6'h04: begin e.ctrl = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0}; e.alu_op = 2'b01; end
            6'h08: e.ctrl = {1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0};
            6'h02: e.ctrl = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic step(input logic en, input logic fl, input logic [31:0] ins,
                        input logic [6:0] pc, input logic wbw, input logic [4:0] wba,
                        input logic [31:0] wbd);
        exp_t e;
        enable        = en;
        flush         = fl;
        instruction   = ins;
        pc_in         = pc;
        wb_reg_write  = wbw;
        wb_write_addr = wba;
        wb_write_data = wbd;
        if (fl)       e = zero_e;
        else if (en)  e = decode_model(ins, pc, wbw, wba, wbd);
        else          e = prev;
        if (wbw && wba != 0) m_regs[wba] = wbd;
        prev = e;
        scb.push_back(e);
        @(posedge clock);
        #1;
        if (scb.size() == 0) chk("scoreboard_empty", 32'd0, 32'd1);
        else                 compare(scb.pop_front());
    endtask

    initial begin
        logic [5:0]  ops [8];
        logic [31:0] rnd;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h11};
        zero_e = '{default: '0};
        prev   = zero_e;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;

        reset = 1'b0; enable = 1'b1; flush = 1'b0; pc_in = '0; instruction = '0;
        wb_reg_write = 1'b0; wb_write_addr = '0; wb_write_data = '0;
        #12;
        compare(zero_e);                 // outputs held at 0 through a clock edge in reset
        reset = 1'b1;

        step(1, 0, 32'h0000_0000, 7'd1, 0, 5'd0, 32'h0);      // NOP decodes as R-type
        step(1, 0, 32'h00E9_4020, 7'd2, 0, 5'd0, 32'h0);      // registers read 0 after reset
        step(1, 0, 32'h0000_0000, 7'd3, 1, 5'd5, 32'h0000_00AA);
        step(1, 0, 32'h00A5_1820, 7'd4, 0, 5'd0, 32'h0);      // ADD r3,r5,r5
        step(1, 0, 32'h8D09_FFFC, 7'd5, 1, 5'd8, 32'h0000_1234); // LW with bypass on rs
        step(1, 0, 32'h0000_0000, 7'd6, 1, 5'd0, 32'h0000_FFFF);
        step(1, 0, 32'h0000_1020, 7'd7, 0, 5'd0, 32'h0);      // reads r0
        step(1, 0, 32'h10A5_0003, 7'd8, 0, 5'd0, 32'h0);      // BEQ
        step(0, 0, 32'hFC00_FFFF, 7'd9, 1, 5'd6, 32'h0000_0066); // stall, write still lands
        step(0, 0, 32'h0800_0025, 7'd10, 0, 5'd0, 32'h0);
        step(0, 1, 32'h8D09_FFFC, 7'd11, 0, 5'd0, 32'h0);     // flush beats stall
        step(1, 0, 32'h00C6_3820, 7'd12, 0, 5'd0, 32'h0);     // reads r6 written in stall
        step(1, 0, 32'hFC00_1234, 7'd13, 0, 5'd0, 32'h0);     // illegal opcode 0x3F
        step(1, 0, 32'h0800_0025, 7'd14, 0, 5'd0, 32'h0);     // J
        step(1, 0, 32'hAD0A_0010, 7'd15, 1, 5'd10, 32'hCAFE_F00D); // SW, bypass on rt
        step(1, 0, 32'h2108_FFFF, 7'd16, 0, 5'd0, 32'h0);     // ADDI
        step(1, 1, 32'h00A5_1820, 7'd17, 0, 5'd0, 32'h0);     // flush while enabled

        for (int i = 0; i < 40; i++) begin
            rnd = $urandom();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 {ops[$urandom_range(0, 7)], rnd[25:0]}, 7'($urandom_range(0, 127)),
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom());
        end

        // Asynchronous reset between edges must clear outputs and the register file.
        #2;
        reset = 1'b0;
        #1;
        compare(zero_e);
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        prev  = zero_e;
        #1;
        reset = 1'b1;
        step(1, 0, 32'h00A5_4020, 7'd99, 0, 5'd0, 32'h0);     // r5 back to 0
        step(1, 0, 32'h8D09_FFFC, 7'd100, 0, 5'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", total, 0);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
Second pipeline stage, directly downstream of the fetch stage. It consumes the registered pc_next and instruction words from fetch and decodes a MIPS subset. It also owns the 32x32 register file, whose write port is driven from write-back. All results are registered into the ID/EX boundary, which feeds the execute stage.

Parameters:
DATA_WIDTH, 32, instruction/register data width
PC_WIDTH, 7, program counter width (matches fetch)
REG_ADDR_WIDTH, 5, register file address width (32 entries)

Ports:
clock  input  1  single rising-edge clock
reset  input  1  asynchronous, active-low reset
enable  input  1  1 = advance ID/EX register; 0 = stall (hold all outputs)
flush  input  1  synchronous bubble insert; overrides enable
pc_in  input  PC_WIDTH  pc_next from fetch
instruction  input  DATA_WIDTH  instruction word from fetch
wb_reg_write  input  1  write-back register write enable
wb_write_addr  input  REG_ADDR_WIDTH  write-back destination register
wb_write_data  input  DATA_WIDTH  write-back data
pc_out  output  PC_WIDTH  registered pc_in
read_data_1  output  DATA_WIDTH  registered rs value
read_data_2  output  DATA_WIDTH  registered rt value
sign_ext_imm  output  DATA_WIDTH  registered sign-extended instruction[15:0]
rs_addr, rt_addr, rd_addr  output  REG_ADDR_WIDTH each  registered instruction fields [25:21], [20:16], [15:11]
funct  output  6  registered instruction[5:0]
jump_target  output  PC_WIDTH  registered instruction[PC_WIDTH-1:0]
reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump  output  1 each  registered control
alu_op  output  2  registered ALU class: 00 add, 01 sub, 10 R-type (use funct)
illegal  output  1  registered: opcode not in the supported set

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; all 32 register file entries 0. Outputs hold at 0 while reset is low.
- Latency: inputs sampled at edge N appear on outputs after edge N. The stage is one cycle deep.
- Decode table (opcode = instruction[31:26]); controls not listed are 0:
  - 0x00 R-type: reg_dst=1, reg_write=1, alu_op=10.
  - 0x23 LW: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00.
  - 0x2B SW: alu_src=1, mem_write=1, alu_op=00.
  - 0x04 BEQ: branch=1, alu_op=01.
  - 0x08 ADDI: alu_src=1, reg_write=1, alu_op=00.
  - 0x02 J: jump=1.
  - Any other opcode: all controls 0 and illegal=1. Data fields still latch.
- Instruction 0x00000000 (NOP) decodes as R-type with rd=0. This is harmless because register 0 is never written.
- Register file:
  - Two asynchronous reads (rs, rt) and one synchronous write on the rising edge.
  - The write occurs when wb_reg_write=1 and wb_write_addr != 0. Register 0 always reads 0.
  - Write-before-read bypass: if wb_reg_write=1, wb_write_addr != 0, and wb_write_addr equals rs or rt, the corresponding read_data latches wb_write_data in that same edge.
  - The write port is independent of enable and flush. Writes occur during a stall or flush.
- Sign extension: sign_ext_imm = {16{instruction[15]}, instruction[15:0]}.
- Stall (enable=0, flush=0): every ID/EX output holds its previous value. Register file writes still occur.
- Flush (flush=1): at the next edge, all control outputs and illegal go to 0 (bubble). Data outputs also go to 0. Flush has priority over a stall.
- If reset is asserted mid-cycle, outputs clear immediately, without waiting for a clock edge. The first edge after reset deasserts behaves as a normal capture.

Test Plan:
- Reset: hold reset=0, then release with enable=1, instruction=0 → all outputs 0 until the first capture. Reading any register returns 0.
- Write-back then read: write 0x0000_00AA to r5. Then decode ADD r3,r5,r5 (0x00A51820) → read_data_1=read_data_2=0xAA, rd_addr=3, reg_dst=1, reg_write=1, alu_op=10.
- Bypass: in the same cycle, wb writes 0x1234 to r8 and decode LW r9,-4(r8) (0x8D09FFFC) → read_data_1=0x1234, sign_ext_imm=0xFFFFFFFC, mem_read=1, mem_to_reg=1, alu_src=1.
- Register 0 guard: wb writes 0xFFFF to r0, then decode reads r0 → read_data_1=0.
- Stall/flush: decode BEQ (0x10A50003), then enable=0 for 2 cycles while the instruction changes → outputs hold branch=1, sign_ext_imm=3. Then flush=1 with enable=0 → all controls 0.
- Illegal/jump: opcode 0x3F → illegal=1, all controls 0. J with instruction=0x08000025 → jump=1, jump_target=0x25.
